instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream stage of the main control decoder. Owns the PC and fetches one instruction at a time over a req/ack instruction-memory handshake.
- Presents the fetched instruction and its opcode field to the decoder.
- Consumes the decoder's jump/branch outputs and the ALU zero flag to compute the next PC when the current instruction retires.
- Adds a fetch timeout with error flag and a retired-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, max cycles a request waits for imem_ack before it is abandoned and re-issued.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  instruction read request, registered.
- imem_addr  out  32  word-aligned fetch address, registered.
- imem_ack  in  1  memory response strobe; imem_rdata valid in the same cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  captured instruction, held while instr_valid.
- opcode  out  6  instr[31:26], to the main decoder.
- instr_valid  out  1  instr/opcode valid for the decoder.
- instr_pc  out  32  PC of the captured instruction.
- pc_plus4  out  32  instr_pc + 4.
- retire  in  1  datapath has committed the current instruction.
- jump  in  1  decoder jump output.
- branch  in  1  decoder branch output.
- zero  in  1  ALU zero flag.
- fetch_err  out  1  one-cycle pulse when a request times out.
- retired_cnt  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC
  - instr=0, instr_valid=0, instr_pc=RESET_PC
  - fetch_err=0, retired_cnt=0, timeout counter=0
- Reset asserted mid-operation discards any outstanding request. A late imem_ack arriving after reset release while not in FETCH is ignored.
- States:
  - IDLE: one cycle after reset release. Next state is FETCH, with imem_req<=1 and imem_addr<=pc.
  - FETCH: imem_req=1, imem_addr held stable. The timeout counter increments each cycle without ack.
    - On imem_ack: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, imem_req<=0, counter<=0, go ISSUE. An ack is accepted in the very first FETCH cycle, so minimum fetch latency is 1 cycle from request to capture.
    - If the counter reaches TIMEOUT-1 without ack: fetch_err pulses for 1 cycle, imem_req<=0 for exactly one cycle, counter<=0, then re-request the same address (state stays FETCH).
  - ISSUE: instr_valid=1; instr, opcode and instr_pc are held; imem_req=0. imem_ack in this state is ignored.
    - On retire: compute next_pc, pc<=next_pc, instr_valid<=0, retired_cnt<=retired_cnt+1, go FETCH with imem_req<=1 and imem_addr<=next_pc in the same edge.
- Next-PC priority, evaluated in the retire cycle:
  - jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}
  - else branch=1 and zero=1: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00})
  - else: pc_plus4
- PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- retire is only honoured in ISSUE; in other states it is ignored.
- retired_cnt wraps to 0 at all-ones.
- jump, branch and zero are sampled only in the retire cycle.
- Throughput: with zero-wait memory and retire asserted in the first ISSUE cycle, one instruction every 2 cycles.
- opcode is combinational from instr and is 0 while instr_valid=0, which decodes as R-type, so the decoder must qualify with instr_valid.

Test Plan:
- Reset then zero-wait memory returning 32'h2008_0005 (addi): imem_req=1 at addr 0 in the 2nd cycle; instr_valid=1 with opcode=6'b001000; retire gives next imem_addr=4 and retired_cnt=1.
- Instr at 0x40 = 32'h0800_0010 (j), retire with jump=1: next imem_addr=0x0000_0040.
- beq at pc=0x100 with imm=16'hFFFE, branch=1, zero=1: next addr=0x0FC. Same with zero=0: next addr=0x104.
- Ack withheld for 16 cycles at addr 0x8: fetch_err pulses once, req drops one cycle then reasserts at 0x8; ack on retry captures normally; retired_cnt unchanged.
- rst_n pulsed low while in FETCH with 3-cycle-latency memory: outputs return to reset values immediately; stale ack one cycle after release is ignored; fetch restarts at RESET_PC.
- pc=0xFFFF_FFFC, retire with no branch/jump: next imem_addr=0; retire asserted during FETCH has no effect on pc or retired_cnt.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over req/ack,
// holds it for the decoder until retire, then steers the PC from jump/branch/zero.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic [5:0]       opcode,
  output logic             instr_valid,
  output logic [31:0]      instr_pc,
  output logic [31:0]      pc_plus4,
  input  logic             retire,
  input  logic             jump,
  input  logic             branch,
  input  logic             zero,
  output logic             fetch_err,
  output logic [CNT_W-1:0] retired_cnt
);

  // Handshake: imem_req stays high with imem_addr stable until imem_ack is seen
  // (rdata valid in the ack cycle); an ack while imem_req is low is ignored.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;

  localparam int          TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [31:0]   pc;
  logic [TW-1:0] to_cnt;
  logic [31:0]   br_off;
  logic [31:0]   next_pc;

  assign pc_plus4 = instr_pc + 32'd4;
  assign opcode   = instr_valid ? instr[31:26] : 6'd0;

  // instr_pc equals pc throughout ISSUE, so pc_plus4 is the sequential successor.
  always_comb begin
    br_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    if (jump)
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (branch && zero)
      next_pc = pc_plus4 + br_off;
    else
      next_pc = pc_plus4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr       <= 32'd0;
      instr_valid <= 1'b0;
      instr_pc    <= RESET_PC;
      fetch_err   <= 1'b0;
      retired_cnt <= '0;
      to_cnt      <= '0;
    end else begin
      fetch_err <= 1'b0;
      case (state)
        IDLE: begin
          state     <= FETCH;
          imem_req  <= 1'b1;
          imem_addr <= pc;
        end
        FETCH: begin
          if (!imem_req) begin
            // one-cycle gap after a timeout, then re-request the same address
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            to_cnt      <= '0;
            state       <= ISSUE;
          end else if (to_cnt == TO_LAST) begin
            fetch_err <= 1'b1;
            imem_req  <= 1'b0;
            to_cnt    <= '0;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        ISSUE: begin
          if (retire) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            retired_cnt <= retired_cnt + CNT_W'(1);
            imem_req    <= 1'b1;
            imem_addr   <= next_pc;
            state       <= FETCH;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: walks a hand-computed program through
// sequential, jump, branch, timeout, wrap and mid-fetch reset scenarios.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        retire;
  logic        jump;
  logic        branch;
  logic        zero;
  logic        fetch_err;
  logic [31:0] retired_cnt;

  int tests_run;
  int tests_failed;

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .TIMEOUT (16),
    .CNT_W   (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .opcode     (opcode),
    .instr_valid(instr_valid),
    .instr_pc   (instr_pc),
    .pc_plus4   (pc_plus4),
    .retire     (retire),
    .jump       (jump),
    .branch     (branch),
    .zero       (zero),
    .fetch_err  (fetch_err),
    .retired_cnt(retired_cnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // memory responds with ack+rdata for one cycle
  task automatic mem_ack(input logic [31:0] data);
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
  endtask

  task automatic do_retire(input logic j, input logic b, input logic z);
    retire = 1'b1;
    jump   = j;
    branch = b;
    zero   = z;
    tick();
    retire = 1'b0;
    jump   = 1'b0;
    branch = 1'b0;
    zero   = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    retire     = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    zero       = 1'b0;

    // reset values
    #12;
    chk("rst_req",   {31'd0, imem_req},    32'd0);
    chk("rst_addr",  imem_addr,            32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr,                32'd0);
    chk("rst_err",   {31'd0, fetch_err},   32'd0);
    chk("rst_cnt",   retired_cnt,          32'd0);
    chk("rst_op",    {26'd0, opcode},      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // IDLE -> FETCH at addr 0
    tick();
    chk("first_req",  {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr,         32'd0);

    // addi, zero-wait
    mem_ack(32'h2008_0005);
    chk("addi_valid",  {31'd0, instr_valid}, 32'd1);
    chk("addi_op",     {26'd0, opcode},      32'h08);
    chk("addi_instr",  instr,                32'h2008_0005);
    chk("addi_pc",     instr_pc,             32'd0);
    chk("addi_pc4",    pc_plus4,             32'd4);
    chk("addi_reqlow", {31'd0, imem_req},    32'd0);
    do_retire(1'b0, 1'b0, 1'b0);
    chk("seq_req",   {31'd0, imem_req},    32'd1);
    chk("seq_addr",  imem_addr,            32'd4);
    chk("seq_cnt",   retired_cnt,          32'd1);
    chk("seq_valid", {31'd0, instr_valid}, 32'd0);

    // j 0x40 from 0x4, then j 0x40 at 0x40
    mem_ack(32'h0800_0010);
    do_retire(1'b1, 1'b0, 1'b0);
    chk("j1_addr", imem_addr, 32'h40);
    mem_ack(32'h0800_0010);
    chk("j2_pc", instr_pc, 32'h40);
    do_retire(1'b1, 1'b0, 1'b0);
    chk("j2_addr", imem_addr,   32'h40);
    chk("j2_cnt",  retired_cnt, 32'd3);

    // j 0x100
    mem_ack(32'h0800_0040);
    do_retire(1'b1, 1'b0, 1'b0);
    chk("j3_addr", imem_addr, 32'h100);

    // beq taken at 0x100, imm -2 -> 0xFC
    mem_ack(32'h1000_FFFE);
    chk("beq_op", {26'd0, opcode}, 32'h04);
    do_retire(1'b0, 1'b1, 1'b1);
    chk("beq_taken", imem_addr, 32'h0FC);

    // nop at 0xFC back to 0x100, beq not taken -> 0x104
    mem_ack(32'h0000_0000);
    do_retire(1'b0, 1'b0, 1'b0);
    chk("nop_addr", imem_addr, 32'h100);
    mem_ack(32'h1000_FFFE);
    do_retire(1'b0, 1'b1, 1'b0);
    chk("beq_not", imem_addr, 32'h104);

    // jump wins over taken branch: j 0x8 (branch target would be 0x110)
    mem_ack(32'h0800_0002);
    do_retire(1'b1, 1'b1, 1'b1);
    chk("jprio_addr", imem_addr,   32'h8);
    chk("jprio_cnt",  retired_cnt, 32'd8);

    // timeout at 0x8: 16 request cycles without ack
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_wait", {30'd0, imem_req, fetch_err}, 32'b10);
    end
    tick();
    chk("to_err",     {31'd0, fetch_err}, 32'd1);
    chk("to_reqlow",  {31'd0, imem_req},  32'd0);
    chk("to_addr",    imem_addr,          32'h8);
    tick();
    chk("to_errclr",  {31'd0, fetch_err}, 32'd0);
    chk("to_reqhigh", {31'd0, imem_req},  32'd1);
    chk("to_readdr",  imem_addr,          32'h8);
    mem_ack(32'h1000_FFFB);
    chk("to_cap_pc",  instr_pc,    32'h8);
    chk("to_cnt",     retired_cnt, 32'd8);
    do_retire(1'b0, 1'b0, 1'b0);
    chk("to_next", imem_addr, 32'hC);

    // beq at 0xC imm -5 -> 0x10 - 0x14 = 0xFFFF_FFFC
    mem_ack(32'h1000_FFFB);
    do_retire(1'b0, 1'b1, 1'b1);
    chk("wrap_tgt", imem_addr,   32'hFFFF_FFFC);
    chk("wrap_cnt", retired_cnt, 32'd10);

    // retire during FETCH is ignored
    retire = 1'b1;
    tick();
    retire = 1'b0;
    chk("fret_addr",  imem_addr,            32'hFFFF_FFFC);
    chk("fret_cnt",   retired_cnt,          32'd10);
    chk("fret_valid", {31'd0, instr_valid}, 32'd0);

    mem_ack(32'h0000_0000);
    chk("wrap_pc4", pc_plus4, 32'd0);

    // ack during ISSUE is ignored
    mem_ack(32'hDEAD_BEEF);
    chk("iss_instr", instr,                32'h0000_0000);
    chk("iss_valid", {31'd0, instr_valid}, 32'd1);
    do_retire(1'b0, 1'b0, 1'b0);
    chk("wrap_addr", imem_addr,   32'd0);
    chk("wrap_cnt2", retired_cnt, 32'd11);

    // j 0x200, then reset mid-fetch with slow memory
    mem_ack(32'h0800_0080);
    do_retire(1'b1, 1'b0, 1'b0);
    chk("slow_addr", imem_addr, 32'h200);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_req",   {31'd0, imem_req},    32'd0);
    chk("mrst_addr",  imem_addr,            32'd0);
    chk("mrst_cnt",   retired_cnt,          32'd0);
    chk("mrst_instr", instr,                32'd0);
    chk("mrst_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // stale ack lands while still IDLE
    mem_ack(32'hDEAD_BEEF);
    chk("stale_req",   {31'd0, imem_req},    32'd1);
    chk("stale_addr",  imem_addr,            32'd0);
    chk("stale_valid", {31'd0, instr_valid}, 32'd0);
    mem_ack(32'h2008_0005);
    chk("restart_valid", {31'd0, instr_valid}, 32'd1);
    chk("restart_pc",    instr_pc,             32'd0);
    chk("restart_instr", instr,                32'h2008_0005);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // hard time limit
  initial begin
    #100000;
    tests_failed++;
    $display("FAIL timeout: observed no finish expected finish");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
